tour_cmd_seq: RTL

TOUR_CMD_SEQ -- requirements
Module: tour_cmd_seq

---
 rtl/tour_pkg.sv | 38 +++
 rtl/tour_move_dec.sv | 41 ++++
 rtl/tour_cmd_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tour_pkg.sv
// tour_pkg: shared types and constants for the knight's-tour command sequencer.
//   state_t       sequencer FSM states
//   OP_*          command opcodes sent to the command processor
//   HDG_*         heading field values (cmd[11:4])
//   LAST_MOVE     index of the final move of a 24-move tour
//   RESP_*        response bytes returned to the UART
package tour_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERT,
    WAIT_V,
    HORZ,
    WAIT_H
  } state_t;

  localparam logic [3:0] OP_MOVE         = 4'h4;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'h5;

  localparam logic [7:0] HDG_NORTH = 8'h00;
  localparam logic [7:0] HDG_WEST  = 8'h3F;
  localparam logic [7:0] HDG_SOUTH = 8'h7F;
  localparam logic [7:0] HDG_EAST  = 8'hBF;

  localparam logic [4:0] LAST_MOVE = 5'd23;

  localparam logic [7:0] RESP_IDLE = 8'hA5;
  localparam logic [7:0] RESP_BUSY = 8'h5A;

  // Command word layout: {opcode, heading, squares}
  function automatic logic [15:0] mk_cmd(input logic [3:0] op,
                                         input logic [7:0] hdg,
                                         input logic [3:0] sq);
    return {op, hdg, sq};
  endfunction

endpackage

// File: rtl/tour_move_dec.sv
// tour_move_dec: decodes a one-hot knight move into a vertical leg and a
// horizontal leg (heading + square count each).
//   move     in  8  one-hot move code
//   v_hdg    out 8  vertical heading (north/south)
//   v_sq     out 4  vertical squares (1 or 2)
//   h_hdg    out 8  horizontal heading (east/west)
//   h_sq     out 4  horizontal squares (1 or 2)
//   illegal  out 1  move is zero or has more than one bit set
module tour_move_dec
  import tour_pkg::*;
(
  input  logic [7:0] move,
  output logic [7:0] v_hdg,
  output logic [3:0] v_sq,
  output logic [7:0] h_hdg,
  output logic [3:0] h_sq,
  output logic       illegal
);

  // Full-value case: any pattern that is not exactly one bit falls to default,
  // which is the one-hot legality check for free.
  always_comb begin
    v_hdg   = HDG_NORTH;
    v_sq    = 4'd0;
    h_hdg   = HDG_EAST;
    h_sq    = 4'd0;
    illegal = 1'b0;
    case (move)
      8'h01: begin v_hdg = HDG_NORTH; v_sq = 4'd2; h_hdg = HDG_EAST; h_sq = 4'd1; end
      8'h02: begin v_hdg = HDG_NORTH; v_sq = 4'd2; h_hdg = HDG_WEST; h_sq = 4'd1; end
      8'h04: begin v_hdg = HDG_NORTH; v_sq = 4'd1; h_hdg = HDG_WEST; h_sq = 4'd2; end
      8'h08: begin v_hdg = HDG_SOUTH; v_sq = 4'd1; h_hdg = HDG_WEST; h_sq = 4'd2; end
      8'h10: begin v_hdg = HDG_SOUTH; v_sq = 4'd2; h_hdg = HDG_WEST; h_sq = 4'd1; end
      8'h20: begin v_hdg = HDG_SOUTH; v_sq = 4'd2; h_hdg = HDG_EAST; h_sq = 4'd1; end
      8'h40: begin v_hdg = HDG_SOUTH; v_sq = 4'd1; h_hdg = HDG_EAST; h_sq = 4'd2; end
      8'h80: begin v_hdg = HDG_NORTH; v_sq = 4'd1; h_hdg = HDG_EAST; h_sq = 4'd2; end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: muxes UART commands through to the command processor while
// idle; once a tour is started it replays the 24-move solution as pairs of
// commands (vertical leg, then horizontal leg with fanfare).
//   clk, rst_n     clock / async active-low reset
//   start_tour     pulse: solution ready, begin sequencing
//   move           one-hot move read from solution memory at mv_indx
//   mv_indx        move index 0..23 to solution memory
//   cmd_UART/cmd_rdy_UART  command from UART (forwarded only in IDLE)
//   clr_cmd_rdy    processor consumed cmd
//   send_resp      processor finished current leg
//   cmd/cmd_rdy    command to processor
//   resp           response byte to UART (A5 idle, 5A touring)
//   tour_err       pulse: illegal move encountered
module tour_cmd_seq
  import tour_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp,
  output logic        tour_err
);

  state_t     state, nxt;
  logic [7:0] move_reg;
  logic [7:0] dec_in;
  logic [7:0] v_hdg, h_hdg;
  logic [3:0] v_sq, h_sq;
  logic       illegal;
  logic       mv_clr, mv_inc, move_done;

  // During LOAD the incoming move is checked before it is committed; afterwards
  // the held copy drives the command fields.
  assign dec_in = (state == LOAD) ? move : move_reg;

  tour_move_dec u_dec (
    .move    (dec_in),
    .v_hdg   (v_hdg),
    .v_sq    (v_sq),
    .h_hdg   (h_hdg),
    .h_sq    (h_sq),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv_indx  <= 5'd0;
      move_reg <= 8'h00;
    end else begin
      if (mv_clr)      mv_indx <= 5'd0;
      else if (mv_inc) mv_indx <= mv_indx + 5'd1;
      if (state == LOAD) move_reg <= move;
    end
  end

  always_comb begin
    nxt       = state;
    cmd       = 16'h0000;
    cmd_rdy   = 1'b0;
    resp      = RESP_BUSY;
    tour_err  = 1'b0;
    mv_clr    = 1'b0;
    mv_inc    = 1'b0;
    move_done = 1'b0;
    case (state)
      IDLE: begin
        cmd     = cmd_UART;
        cmd_rdy = cmd_rdy_UART;
        resp    = RESP_IDLE;
        if (start_tour) begin
          mv_clr = 1'b1;
          nxt    = LOAD;
        end
      end
      LOAD: begin
        if (illegal) begin
          tour_err = 1'b1;
          nxt      = IDLE;
        end else begin
          nxt = VERT;
        end
      end
      VERT: begin
        cmd     = mk_cmd(OP_MOVE, v_hdg, v_sq);
        cmd_rdy = 1'b1;
        // send_resp alone is ignored until the command has been taken
        if (clr_cmd_rdy) nxt = send_resp ? HORZ : WAIT_V;
      end
      WAIT_V: begin
        cmd = mk_cmd(OP_MOVE, v_hdg, v_sq);
        if (send_resp) nxt = HORZ;
      end
      HORZ: begin
        cmd     = mk_cmd(OP_MOVE_FANFARE, h_hdg, h_sq);
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) begin
          if (send_resp) move_done = 1'b1;
          else           nxt = WAIT_H;
        end
      end
      WAIT_H: begin
        cmd = mk_cmd(OP_MOVE_FANFARE, h_hdg, h_sq);
        if (send_resp) move_done = 1'b1;
      end
      default: nxt = IDLE;
    endcase

    // End of a move: finish the tour or step to the next index (never past 23).
    if (move_done) begin
      if (mv_indx == LAST_MOVE) begin
        nxt = IDLE;
      end else begin
        nxt    = LOAD;
        mv_inc = 1'b1;
      end
    end
  end

endmodule
